// File: rtl/pea_pkg.sv
// Shared PEA definitions: datapath width and divider-arbiter state/constants.
package pea_pkg;

    localparam int N_BITS        = 32;
    localparam int DIV_ARB_N_REQ = 4;

    // Result returned to a PE when the divider never answers.
    localparam logic [N_BITS-1:0] DIV_TIMEOUT_RES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_arb_state_e;

endpackage

// File: rtl/pea_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// searching cyclically. Returns a one-hot grant and its encoded index.
module pea_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[IW'((int'(ptr_i) + i) % N_REQ)]) begin
                found = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % N_REQ);
            end
        end
        if (found) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/pea_div_arbiter.sv
// Shares one iterative divider between N_REQ PEs, one transaction in flight.
// Build option PEA_DIV_ARB_TIMEOUT_EN adds a WAIT watchdog that answers all-ones + err_o.
module pea_div_arbiter #(
    parameter int N_REQ          = pea_pkg::DIV_ARB_N_REQ,
    parameter int N_BITS         = pea_pkg::N_BITS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_a_i,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_b_i,
    input  logic [N_REQ-1:0]              req_signed_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic [N_REQ-1:0]              resp_valid_o,
    output logic [N_BITS-1:0]             resp_res_o,
    output logic                          err_o,
    output logic                          div_in_vld_o,
    output logic [N_BITS-1:0]             div_op_a_o,
    output logic [N_BITS-1:0]             div_op_b_o,
    output logic                          div_signed_o,
    output logic                          div_out_rdy_o,
    input  logic                          div_out_vld_i,
    input  logic [N_BITS-1:0]             div_res_i
);

    import pea_pkg::*;

    localparam int IW = $clog2(N_REQ);

    div_arb_state_e    state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [N_BITS-1:0] res_q, res_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              tmo_hit;

    pea_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

`ifdef PEA_DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign tmo_hit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    // A real result arriving on the timeout cycle takes priority.
    assign err_d   = tmo_hit && !div_out_vld_i;
    assign err_o   = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    owner_d = arb_idx;
                    a_d     = req_a_i[arb_idx];
                    b_d     = req_b_i[arb_idx];
                    sgn_d   = req_signed_i[arb_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (div_out_vld_i) begin
                    res_d   = div_res_i;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    res_d   = N_BITS'(DIV_TIMEOUT_RES);
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (state_q == RESP) resp_valid_o[owner_q] = 1'b1;
    end

    assign req_ready_o   = (state_q == IDLE) ? arb_gnt : '0;
    assign resp_res_o    = res_q;
    assign div_in_vld_o  = (state_q == ISSUE);
    assign div_out_rdy_o = (state_q == WAIT);
    assign div_op_a_o    = a_q;
    assign div_op_b_o    = b_q;
    assign div_signed_o  = sgn_q;

endmodule

// File: doc/pea_div_arbiter.md
Name: pea_div_arbiter

Overview:
- Shares one iterative signed/unsigned divider between N_REQ PEs of the PEA.
- Round-robin arbitration: each PE functional unit raises a divide request; the arbiter grants one, latches its operands and issues them to the divider.
- Waits for divider completion, then returns the result to the granted PE as a one-cycle response pulse.
- Exactly one division is in flight at a time; there is no operand queueing beyond the latched transaction.

Parameters:
- N_REQ, 4, number of requesting PEs; range 2..16.
- N_BITS, 32, operand and result width; defaults to the pea_pkg N_BITS value.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  N_REQ  per-PE divide request
- req_a_i  in  N_REQ x N_BITS  per-PE dividend
- req_b_i  in  N_REQ x N_BITS  per-PE divisor
- req_signed_i  in  N_REQ  1 = DIV, 0 = DIVU
- req_ready_o  out  N_REQ  one-hot grant/accept
- resp_valid_o  out  N_REQ  one-hot result strobe
- resp_res_o  out  N_BITS  result, broadcast to all PEs
- err_o  out  1  timeout flag (pulse)
- div_in_vld_o  out  1  issue strobe to divider
- div_op_a_o  out  N_BITS  dividend to divider
- div_op_b_o  out  N_BITS  divisor to divider
- div_signed_o  out  1  signed-operation select
- div_out_rdy_o  out  1  result accept
- div_out_vld_i  in  1  divider result valid
- div_res_i  in  N_BITS  divider result

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; operand, result and owner registers 0.
- Reset asserted mid-operation aborts the transaction. No response is issued, and the divider is expected to be reset by the same rst_n_i.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is high, select the first valid index at or after the pointer, cyclically.
  - req_ready_o[g] = 1 combinationally in that cycle only.
  - Latch a, b, signed and owner = g; go to ISSUE.
  - If no request is valid, stay in IDLE.
  - req_ready_o is 0 in every other state.
- ISSUE: div_in_vld_o = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - div_out_rdy_o = 1.
  - When div_out_vld_i = 1, latch div_res_i and go to RESP.
  - A div_out_vld_i seen in any state other than WAIT is ignored.
- RESP:
  - resp_valid_o[owner] = 1 and resp_res_o = latched result for exactly one cycle.
  - Pointer <= owner + 1, wrapping N_REQ-1 -> 0.
  - Go to IDLE.
- resp_res_o holds its last value outside RESP.
- Requesters have no back-pressure; they must sample the response in RESP.
- div_op_a_o, div_op_b_o and div_signed_o are driven from registers and stay stable from ISSUE through WAIT.
- Latency: accept in cycle T, issue in T+1. If div_out_vld_i is high in cycle W, resp_valid_o is high in W+1. Minimum accept-to-response is 3 cycles.
- Throughput: the next grant can occur in the IDLE cycle right after RESP, so the accept-to-accept gap is at least 4 cycles.
- A requester must hold req_valid_i and its operands until it sees req_ready_o.
- A requester with resp pending must not re-request; a re-request is not detected and is simply granted again later.
- Divide-by-zero and overflow are not checked here; results pass through from the divider unchanged.
- Simultaneous requests: exactly one grant per IDLE cycle. Each requester waits at most N_REQ-1 transactions before it is granted.

Optional Feature:
- Macro: PEA_DIV_ARB_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without div_out_vld_i, the arbiter goes to RESP with result all-ones and pulses err_o together with resp_valid_o.
  - The counter clears on leaving WAIT.
  - A div_out_vld_i in the same cycle as the timeout wins, and err_o stays 0.
- Disabled: no counter is built, err_o is tied to 0, and WAIT lasts indefinitely.

Decomposition:
- pea_pkg additions:
  - div_arb_state_e (IDLE, ISSUE, WAIT, RESP).
  - DIV_ARB_N_REQ default constant.
  - DIV_TIMEOUT_RES constant (all-ones).
- One sub-module: pea_rr_arbiter.
  - Inputs: req vector, pointer. Output: one-hot grant plus encoded index.
  - Purely combinational and reusable by other shared-resource arbiters.

Test Plan:
- Single request: PE1 requests a=100, b=7, signed; divider responds after 5 cycles -> req_ready_o = 0010 in T; div_in_vld_o in T+1; resp_valid_o = 0010 with res 14 one cycle after div_out_vld_i; pointer = 2.
- All four PEs request from reset with a=i*10, b=3 -> grant order 0,1,2,3; responses 0,3,6,10 to the matching one-hot; no overlapping div_in_vld_o.
- Fairness: PE0 and PE3 request continuously -> grants alternate 0,3,0,3.
- Signed path: PE2 requests a=-20, b=3, signed=1 -> div_signed_o = 1, operands unchanged; res -6 forwarded.
- Reset asserted in WAIT -> all outputs 0 within the reset cycle; a fresh request afterwards is granted to the lowest valid index.
- With PEA_DIV_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, divider never responds -> resp_valid_o with res 0xFFFFFFFF and err_o = 1; without the macro the arbiter stays in WAIT and err_o stays 0.
